oport_arbiter: RTL and testbench

// - Per-output-port scheduler for the switch fabric.
// - Shares one fabric output among NUM_IN input buffers. Each buffer presents packed 142-bit words.
// - Grants are round-robin and locked for the whole packet. Only head words whose dest matches PORT_ID may win.
// - Drives a 1-deep registered output stage toward the output link.

---
 rtl/fabric_pkg.sv | 23 ++
 rtl/rr_arbiter.sv | 26 ++
 rtl/oport_arbiter.sv | 129 ++++++++++++
 tb/tb_oport_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fabric_pkg.sv
// Shared fabric word layout, arbiter state encoding and word-decode helpers.
// Each 142-bit word is two 71-bit halves {valid,sop,eop,empty[2:0],error,data[63:0]}.
package fabric_pkg;

  localparam int PKT_W       = 142;
  localparam int HALF_PACKET = PKT_W / 2;
  localparam int SOP_HI      = PKT_W - 2;
  localparam int EOP_HI      = PKT_W - 3;
  localparam int EOP_LO      = HALF_PACKET - 3;
  localparam int DEST_MSB    = PKT_W - 8;

  typedef enum logic {ST_IDLE, ST_LOCKED} arb_state_t;

  function automatic logic is_head(input logic [PKT_W-1:0] w);
    return w[SOP_HI];
  endfunction

  // A packet may end in either half of its last word.
  function automatic logic is_tail(input logic [PKT_W-1:0] w);
    return w[EOP_HI] | w[EOP_LO];
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational mask-based round-robin arbiter: lowest requester at or above ptr wins,
// otherwise wrap to the lowest requester overall. No latency, no backpressure.
module rr_arbiter #(
  parameter int N     = 4,
  parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     gnt
);

  logic [N-1:0] mask;
  logic [N-1:0] masked;
  logic [N-1:0] pick;

  always_comb begin
    mask = '0;
    for (int i = 0; i < N; i++) begin
      mask[i] = (i >= int'(ptr));
    end
    masked = req & mask;
    pick   = (|masked) ? masked : req;
    gnt    = pick & (~pick + N'(1));
  end

endmodule

// File: rtl/oport_arbiter.sv
// Per-output-port packet scheduler: round-robin grant locked for a whole packet, 1-deep output register.
// Accepted word appears one cycle later; o_ready drops for every input while the output is held.
module oport_arbiter
  import fabric_pkg::*;
#(
  parameter int NUM_IN       = 4,
  parameter int PACKET_WIDTH = 142,
  parameter int DEST_WIDTH   = 4,
  parameter int PORT_ID      = 0
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic [NUM_IN-1:0]              i_valid,
  input  logic [NUM_IN*PACKET_WIDTH-1:0] i_data,
  input  logic [NUM_IN*DEST_WIDTH-1:0]   i_dest,
  output logic [NUM_IN-1:0]              o_ready,
  output logic                           o_valid,
  output logic [PACKET_WIDTH-1:0]        o_data,
  output logic [DEST_WIDTH-1:0]          o_dest,
  input  logic                           i_ready,
  output logic [NUM_IN-1:0]              o_grant,
  output logic                           o_busy
);

  localparam int PTR_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;
  localparam logic [DEST_WIDTH-1:0] MY_PORT = DEST_WIDTH'(PORT_ID);
  localparam logic [PTR_W-1:0]      LAST_IN = PTR_W'(NUM_IN - 1);

  arb_state_t              state;
  logic [PTR_W-1:0]        rr_ptr;
  logic [PTR_W-1:0]        owner;
  logic [PTR_W-1:0]        gnt_idx;
  logic [PTR_W-1:0]        next_ptr;
  logic [NUM_IN-1:0]       req;
  logic [NUM_IN-1:0]       rr_gnt;
  logic [NUM_IN-1:0]       grant;
  logic [NUM_IN-1:0]       take;
  logic                    ld;
  logic                    accept;
  logic                    acc_tail;
  logic [PACKET_WIDTH-1:0] mux_data;
  logic [DEST_WIDTH-1:0]   mux_dest;

  // Only head words addressed to this port compete, and only while no packet owns the output.
  always_comb begin
    req = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      req[k] = (state == ST_IDLE) && i_valid[k]
               && is_head(i_data[k*PACKET_WIDTH +: PACKET_WIDTH])
               && (i_dest[k*DEST_WIDTH +: DEST_WIDTH] == MY_PORT);
    end
  end

  rr_arbiter #(
    .N     (NUM_IN),
    .PTR_W (PTR_W)
  ) u_rr (
    .req (req),
    .ptr (rr_ptr),
    .gnt (rr_gnt)
  );

  // Grant is forced low in reset so no input sees an accept while the output stage is cleared.
  always_comb begin
    grant = '0;
    if (reset_n) begin
      if (state == ST_LOCKED) begin
        grant[owner] = 1'b1;
      end else begin
        grant = rr_gnt;
      end
    end
  end

  assign ld      = !o_valid || i_ready;
  assign o_ready = grant & {NUM_IN{ld}};
  assign take    = o_ready & i_valid;
  assign accept  = |take;
  assign o_grant = grant;

  always_comb begin
    gnt_idx  = '0;
    mux_data = '0;
    mux_dest = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      if (grant[k]) begin
        gnt_idx  = PTR_W'(k);
        mux_data = mux_data | i_data[k*PACKET_WIDTH +: PACKET_WIDTH];
        mux_dest = mux_dest | i_dest[k*DEST_WIDTH +: DEST_WIDTH];
      end
    end
  end

  assign acc_tail = is_tail(mux_data);
  assign next_ptr = (gnt_idx == LAST_IN) ? '0 : gnt_idx + PTR_W'(1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= ST_IDLE;
      rr_ptr  <= '0;
      owner   <= '0;
      o_valid <= 1'b0;
      o_data  <= '0;
      o_dest  <= '0;
      o_busy  <= 1'b0;
    end else begin
      if (ld) begin
        o_valid <= accept;
      end
      if (accept) begin
        o_data <= mux_data;
        // Every word accepted in IDLE is a head, so dest is captured once per packet.
        if (state == ST_IDLE) begin
          o_dest <= mux_dest;
        end
        if (acc_tail) begin
          state  <= ST_IDLE;
          rr_ptr <= next_ptr;
          o_busy <= 1'b0;
        end else if (state == ST_IDLE) begin
          state  <= ST_LOCKED;
          owner  <= gnt_idx;
          o_busy <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_oport_arbiter.sv
// Directed bench for oport_arbiter: single words, locked packets, round-robin order,
// backpressure, dest filtering and mid-packet reset.
module tb_oport_arbiter;

  localparam int NI  = 4;
  localparam int PW  = 142;
  localparam int DW  = 4;
  localparam int PID = 5;

  logic                 clk = 1'b0;
  logic                 reset_n;
  logic [NI-1:0]        i_valid;
  logic [NI*PW-1:0]     i_data;
  logic [NI*DW-1:0]     i_dest;
  logic [NI-1:0]        o_ready;
  logic                 o_valid;
  logic [PW-1:0]        o_data;
  logic [DW-1:0]        o_dest;
  logic                 i_ready;
  logic [NI-1:0]        o_grant;
  logic                 o_busy;

  int total = 0;
  int bad   = 0;

  oport_arbiter #(
    .NUM_IN       (NI),
    .PACKET_WIDTH (PW),
    .DEST_WIDTH   (DW),
    .PORT_ID      (PID)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .i_valid (i_valid),
    .i_data  (i_data),
    .i_dest  (i_dest),
    .o_ready (o_ready),
    .o_valid (o_valid),
    .o_data  (o_data),
    .o_dest  (o_dest),
    .i_ready (i_ready),
    .o_grant (o_grant),
    .o_busy  (o_busy)
  );

  always #5 clk = ~clk;

  function automatic logic [PW-1:0] mk(input logic sop, input logic eh, input logic el,
                                       input logic [15:0] tag);
    return {1'b1, sop, eh, 3'b000, 1'b0, {4{tag}}, 1'b1, 1'b0, el, 3'b000, 1'b0, {4{~tag}}};
  endfunction

  task automatic set_in(input int k, input logic [PW-1:0] w, input logic [DW-1:0] d,
                        input logic v);
    i_valid[k]         = v;
    i_data[k*PW +: PW] = w;
    i_dest[k*DW +: DW] = d;
  endtask

  task automatic clear_inputs();
    i_valid = '0;
    i_data  = '0;
    i_dest  = '0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    i_ready = 1'b1;
    clear_inputs();
    set_in(0, mk(1'b1, 1'b1, 1'b0, 16'h0001), DW'(PID), 1'b1);
    repeat (2) @(posedge clk);
    #1;
    total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", o_valid); end
    total++; if (o_data !== '0) begin bad++; $display("FAIL rst_data got=%h exp=0", o_data); end
    total++; if (o_dest !== '0) begin bad++; $display("FAIL rst_dest got=%h exp=0", o_dest); end
    total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", o_busy); end
    total++; if (o_grant !== 4'b0000) begin bad++; $display("FAIL rst_grant got=%b exp=0000", o_grant); end
    total++; if (o_ready !== 4'b0000) begin bad++; $display("FAIL rst_ready got=%b exp=0000", o_ready); end
    @(negedge clk);
    clear_inputs();
    reset_n = 1'b1;
  endtask

  task automatic test_single();
    logic [PW-1:0] w, w0, w1;
    w  = mk(1'b1, 1'b1, 1'b0, 16'h0A01);
    w0 = mk(1'b1, 1'b1, 1'b0, 16'h0B00);
    w1 = mk(1'b1, 1'b1, 1'b0, 16'h0B01);
    @(negedge clk);
    set_in(0, w, DW'(PID), 1'b1);
    #1;
    total++; if (o_ready !== 4'b0001) begin bad++; $display("FAIL t1_ready got=%b exp=0001", o_ready); end
    total++; if (o_grant !== 4'b0001) begin bad++; $display("FAIL t1_grant got=%b exp=0001", o_grant); end
    @(posedge clk); #1;
    total++; if (o_valid !== 1'b1) begin bad++; $display("FAIL t1_valid got=%b exp=1", o_valid); end
    total++; if (o_data !== w) begin bad++; $display("FAIL t1_data got=%h exp=%h", o_data, w); end
    total++; if (o_dest !== DW'(PID)) begin bad++; $display("FAIL t1_dest got=%h exp=%h", o_dest, DW'(PID)); end
    total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL t1_busy got=%b exp=0", o_busy); end
    // rr_ptr must now be 1: with in0 and in1 both asking, in1 wins.
    @(negedge clk);
    clear_inputs();
    set_in(0, w0, DW'(PID), 1'b1);
    set_in(1, w1, DW'(PID), 1'b1);
    #1;
    total++; if (o_grant !== 4'b0010) begin bad++; $display("FAIL t1_ptr_grant got=%b exp=0010", o_grant); end
    @(posedge clk); #1;
    total++; if (o_data !== w1) begin bad++; $display("FAIL t1_ptr_data got=%h exp=%h", o_data, w1); end
    @(negedge clk);
    clear_inputs();
    @(posedge clk); #1;
    total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL t1_drain got=%b exp=0", o_valid); end
  endtask

  task automatic test_locked_packet();
    logic [PW-1:0] a, b, c, h1;
    a  = mk(1'b1, 1'b0, 1'b0, 16'h0C00);
    b  = mk(1'b0, 1'b0, 1'b0, 16'h0C01);
    c  = mk(1'b0, 1'b0, 1'b1, 16'h0C02);
    h1 = mk(1'b1, 1'b1, 1'b0, 16'h0C10);
    @(negedge clk);
    set_in(2, a, DW'(PID), 1'b1);
    set_in(1, h1, DW'(PID), 1'b1);
    #1;
    total++; if (o_ready !== 4'b0100) begin bad++; $display("FAIL t2_ready_a got=%b exp=0100", o_ready); end
    total++; if (o_grant !== 4'b0100) begin bad++; $display("FAIL t2_grant_a got=%b exp=0100", o_grant); end
    @(posedge clk); #1;
    total++; if (o_data !== a) begin bad++; $display("FAIL t2_data_a got=%h exp=%h", o_data, a); end
    total++; if (o_busy !== 1'b1) begin bad++; $display("FAIL t2_busy_a got=%b exp=1", o_busy); end
    total++; if (o_dest !== DW'(PID)) begin bad++; $display("FAIL t2_dest_a got=%h exp=%h", o_dest, DW'(PID)); end
    @(negedge clk);
    set_in(2, b, 4'hF, 1'b1);
    #1;
    total++; if (o_grant !== 4'b0100) begin bad++; $display("FAIL t2_grant_b got=%b exp=0100", o_grant); end
    @(posedge clk); #1;
    total++; if (o_data !== b) begin bad++; $display("FAIL t2_data_b got=%h exp=%h", o_data, b); end
    total++; if (o_dest !== DW'(PID)) begin bad++; $display("FAIL t2_dest_b got=%h exp=%h", o_dest, DW'(PID)); end
    @(negedge clk);
    set_in(2, c, 4'hE, 1'b1);
    #1;
    total++; if (o_ready !== 4'b0100) begin bad++; $display("FAIL t2_ready_c got=%b exp=0100", o_ready); end
    @(posedge clk); #1;
    total++; if (o_data !== c) begin bad++; $display("FAIL t2_data_c got=%h exp=%h", o_data, c); end
    total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL t2_busy_c got=%b exp=0", o_busy); end
    total++; if (o_dest !== DW'(PID)) begin bad++; $display("FAIL t2_dest_c got=%h exp=%h", o_dest, DW'(PID)); end
    @(negedge clk);
    set_in(2, '0, '0, 1'b0);
    #1;
    total++; if (o_grant !== 4'b0010) begin bad++; $display("FAIL t2_grant_in1 got=%b exp=0010", o_grant); end
    @(posedge clk); #1;
    total++; if (o_data !== h1) begin bad++; $display("FAIL t2_data_in1 got=%h exp=%h", o_data, h1); end
    @(negedge clk);
    clear_inputs();
    @(posedge clk); #1;
  endtask

  task automatic test_round_robin();
    logic [PW-1:0] wr [NI];
    logic [NI-1:0] exp_g;
    @(negedge clk);
    reset_n = 1'b0;
    clear_inputs();
    @(negedge clk);
    reset_n = 1'b1;
    for (int k = 0; k < NI; k++) wr[k] = mk(1'b1, 1'b1, 1'b0, 16'h0D00 + 16'(k));
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i == 0) begin
        for (int k = 0; k < NI; k++) set_in(k, wr[k], DW'(PID), 1'b1);
      end
      exp_g = NI'(1 << (i % NI));
      #1;
      total++; if (o_grant !== exp_g) begin bad++; $display("FAIL t3_grant_%0d got=%b exp=%b", i, o_grant, exp_g); end
      @(posedge clk); #1;
      total++; if (o_data !== wr[i % NI]) begin bad++; $display("FAIL t3_data_%0d got=%h exp=%h", i, o_data, wr[i % NI]); end
    end
    @(negedge clk);
    clear_inputs();
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    logic [PW-1:0] p [4];
    p[0] = mk(1'b1, 1'b0, 1'b0, 16'h0E00);
    p[1] = mk(1'b0, 1'b0, 1'b0, 16'h0E01);
    p[2] = mk(1'b0, 1'b0, 1'b0, 16'h0E02);
    p[3] = mk(1'b0, 1'b1, 1'b0, 16'h0E03);
    @(negedge clk);
    set_in(0, p[0], DW'(PID), 1'b1);
    @(posedge clk);
    @(negedge clk);
    set_in(0, p[1], DW'(PID), 1'b1);
    #1;
    total++; if (o_ready !== 4'b0001) begin bad++; $display("FAIL t4_ready_p1 got=%b exp=0001", o_ready); end
    @(posedge clk); #1;
    total++; if (o_data !== p[1]) begin bad++; $display("FAIL t4_data_p1 got=%h exp=%h", o_data, p[1]); end
    for (int s = 0; s < 5; s++) begin
      @(negedge clk);
      if (s == 0) begin
        set_in(0, p[2], DW'(PID), 1'b1);
        i_ready = 1'b0;
      end
      #1;
      total++; if (o_ready !== 4'b0000) begin bad++; $display("FAIL t4_stall_ready_%0d got=%b exp=0000", s, o_ready); end
      @(posedge clk); #1;
      total++; if (o_data !== p[1]) begin bad++; $display("FAIL t4_stall_data_%0d got=%h exp=%h", s, o_data, p[1]); end
      total++; if (o_valid !== 1'b1) begin bad++; $display("FAIL t4_stall_valid_%0d got=%b exp=1", s, o_valid); end
    end
    @(negedge clk);
    i_ready = 1'b1;
    #1;
    total++; if (o_ready !== 4'b0001) begin bad++; $display("FAIL t4_resume_ready got=%b exp=0001", o_ready); end
    @(posedge clk); #1;
    total++; if (o_data !== p[2]) begin bad++; $display("FAIL t4_data_p2 got=%h exp=%h", o_data, p[2]); end
    @(negedge clk);
    set_in(0, p[3], DW'(PID), 1'b1);
    @(posedge clk); #1;
    total++; if (o_data !== p[3]) begin bad++; $display("FAIL t4_data_p3 got=%h exp=%h", o_data, p[3]); end
    total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL t4_busy_end got=%b exp=0", o_busy); end
    @(negedge clk);
    clear_inputs();
    @(posedge clk); #1;
    total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL t4_drain got=%b exp=0", o_valid); end
  endtask

  task automatic test_dest_filter();
    @(negedge clk);
    set_in(0, mk(1'b1, 1'b1, 1'b0, 16'h0F0F), DW'(PID + 1), 1'b1);
    for (int i = 0; i < 6; i++) begin
      #1;
      total++; if (o_ready !== 4'b0000) begin bad++; $display("FAIL t5_ready_%0d got=%b exp=0000", i, o_ready); end
      @(posedge clk); #1;
      total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL t5_valid_%0d got=%b exp=0", i, o_valid); end
      @(negedge clk);
    end
    clear_inputs();
  endtask

  task automatic test_reset_mid_packet();
    logic [PW-1:0] q0, q1, f0, f1;
    q0 = mk(1'b1, 1'b0, 1'b0, 16'h1F00);
    q1 = mk(1'b0, 1'b0, 1'b0, 16'h1F01);
    f0 = mk(1'b1, 1'b0, 1'b0, 16'h1F10);
    f1 = mk(1'b0, 1'b1, 1'b0, 16'h1F11);
    @(negedge clk);
    set_in(3, q0, DW'(PID), 1'b1);
    #1;
    total++; if (o_ready !== 4'b1000) begin bad++; $display("FAIL t6_ready_q0 got=%b exp=1000", o_ready); end
    @(posedge clk); #1;
    total++; if (o_busy !== 1'b1) begin bad++; $display("FAIL t6_busy_q0 got=%b exp=1", o_busy); end
    @(negedge clk);
    set_in(3, q1, DW'(PID), 1'b1);
    reset_n = 1'b0;
    #1;
    total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL t6_rst_valid got=%b exp=0", o_valid); end
    total++; if (o_data !== '0) begin bad++; $display("FAIL t6_rst_data got=%h exp=0", o_data); end
    total++; if (o_dest !== '0) begin bad++; $display("FAIL t6_rst_dest got=%h exp=0", o_dest); end
    total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL t6_rst_busy got=%b exp=0", o_busy); end
    total++; if (o_grant !== 4'b0000) begin bad++; $display("FAIL t6_rst_grant got=%b exp=0000", o_grant); end
    total++; if (o_ready !== 4'b0000) begin bad++; $display("FAIL t6_rst_ready got=%b exp=0000", o_ready); end
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    total++; if (o_ready !== 4'b0000) begin bad++; $display("FAIL t6_nonhead_ready got=%b exp=0000", o_ready); end
    @(posedge clk); #1;
    total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL t6_nonhead_valid got=%b exp=0", o_valid); end
    @(negedge clk);
    set_in(3, f0, DW'(PID), 1'b1);
    #1;
    total++; if (o_grant !== 4'b1000) begin bad++; $display("FAIL t6_fresh_grant got=%b exp=1000", o_grant); end
    @(posedge clk); #1;
    total++; if (o_data !== f0) begin bad++; $display("FAIL t6_fresh_data got=%h exp=%h", o_data, f0); end
    total++; if (o_dest !== DW'(PID)) begin bad++; $display("FAIL t6_fresh_dest got=%h exp=%h", o_dest, DW'(PID)); end
    total++; if (o_busy !== 1'b1) begin bad++; $display("FAIL t6_fresh_busy got=%b exp=1", o_busy); end
    @(negedge clk);
    set_in(3, f1, DW'(PID), 1'b1);
    @(posedge clk); #1;
    total++; if (o_data !== f1) begin bad++; $display("FAIL t6_tail_data got=%h exp=%h", o_data, f1); end
    total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL t6_tail_busy got=%b exp=0", o_busy); end
    @(negedge clk);
    clear_inputs();
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single();
    test_locked_packet();
    test_round_robin();
    test_backpressure();
    test_dest_filter();
    test_reset_mid_packet();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
